tt_um_accum_pipe: RTL and testbench
===================================

TT_UM_ACCUM_PIPE -- requirements
Module: tt_um_accum_pipe

Interface
- REQ-001: Parameter ACC_W, default 16: accumulator width in bits, legal range 8..16.
- REQ-002: Parameter SYNC_STAGES, default 2: strobe synchroniser depth, legal range 2..3.
- REQ-003: clk  input  1  the single clock; all state SHALL be clocked on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: ena  input  1  design enable; strobe edges SHALL be ignored while 0.
- REQ-006: ui_in  input  8  operand A.
- REQ-007: uio_in  input  8  control: [1:0] op, [2] strobe, [3] byte select; [7:4] SHALL be ignored.
- REQ-008: uo_out  output  8  selected accumulator byte.
- REQ-009: uio_out  output  8  status: [4] carry, [5] zero, [6] sticky overflow, [7] busy; [3:0] SHALL be 0.
- REQ-010: uio_oe  output  8  SHALL be constant 8'hF0.

Function
- REQ-011: Strobe SHALL pass through a SYNC_STAGES flop chain; a command SHALL be accepted on the cycle the synchronised strobe is high and its previous value was low, with ena=1.
- REQ-012: On acceptance, stage 1 SHALL capture ui_in and op and set busy; the stage-1 capture edge is edge k+SYNC_STAGES, where edge k is the first edge at which strobe is sampled high.
- REQ-013: The accumulator SHALL update on the edge after stage-1 capture (edge k+SYNC_STAGES+1); busy SHALL clear on that same edge unless a new command is captured.
- REQ-014: Op 00 LOAD: acc = zero-extended A; carry = 0.
- REQ-015: Op 01 ADD: acc = acc + A, unsigned; carry = carry-out of bit ACC_W-1.
- REQ-016: Op 10 SUB: acc = acc - A, unsigned; carry = borrow.
- REQ-017: Op 11 CLEAR: acc = 0; carry = 0; sticky overflow = 0.
- REQ-018: Sticky overflow SHALL be set on any ADD or SUB with carry=1, and cleared only by CLEAR or reset.
- REQ-019: Zero flag SHALL be combinational (acc == 0), evaluated on the registered acc.
- REQ-020: uo_out SHALL be acc[7:0] when select=0, and acc[ACC_W-1:8] zero-padded to 8 bits when select=1; it SHALL be 0 when ACC_W = 8 and select=1.
- REQ-021: The output mux SHALL be combinational on registered state; select changes SHALL take effect in the same cycle.
- REQ-022: Strobe held high SHALL issue exactly one command; a new command requires strobe low for at least one synchronised sample.
- REQ-023: ena dropping while busy SHALL NOT abort the stage-1 command; it SHALL complete.

Reset
- REQ-024: rst_n low SHALL asynchronously clear the synchroniser, the edge-detect flop, stage 1, acc, carry and sticky overflow.
- REQ-025: During and after reset, uo_out = 0, uio_out = 8'h20 (zero flag only), and uio_oe = 8'hF0.
- REQ-026: A command in flight when reset asserts SHALL be discarded.
- REQ-027: A strobe already high when reset releases SHALL be accepted once it has passed the synchroniser.

Configuration
- REQ-028: Macro TT_ACC_SAT_EN defined: ADD SHALL clamp to 2^ACC_W-1 and SUB SHALL clamp to 0 on carry/borrow; carry and sticky overflow are still set.
- REQ-029: Macro TT_ACC_SAT_EN undefined: ADD and SUB SHALL wrap modulo 2^ACC_W.

Structure
- REQ-030: Package tt_acc_pkg SHALL hold the op encoding (LOAD, ADD, SUB, CLEAR), the status bit indices, and the ACC_W and SYNC_STAGES defaults.
- REQ-031: Sub-module tt_acc_sync_edge SHALL implement the synchroniser plus rising-edge detector, parametrised by SYNC_STAGES.

Verification
- REQ-032: Reset, then pulse LOAD with A=8'hF0 -> acc=16'h00F0 at edge k+3; uo_out=F0; busy high for exactly one cycle.
- REQ-033: LOAD FF, then ADD 01 with ACC_W=8 -> wrap build: acc=00, carry=1, ovf=1, zero=1; TT_ACC_SAT_EN build: acc=FF, carry=1, ovf=1.
- REQ-034: ACC_W=16: LOAD 00, SUB 01 -> wrap: acc=FFFF, uo_out=FF for both select values; saturating: acc=0000.
- REQ-035: Strobe held high for 20 cycles with ADD 05 -> acc incremented by 5 exactly once.
- REQ-036: ena=0 during a strobe pulse -> no acc change and busy stays 0; CLEAR after an overflow -> ovf=0, uio_out=8'h20.
- REQ-037: Assert rst_n low one cycle after stage-1 capture of ADD 10 -> acc=0, busy=0, and no update after reset release.

Source files
------------

// File: rtl/tt_acc_pkg.sv
// Shared definitions for the strobed accumulator: op encoding, control/status bit
// positions, stage-1 command record and parameter defaults.
package tt_acc_pkg;

    localparam int ACC_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // uio_in control bits
    localparam int CTRL_STB = 2;
    localparam int CTRL_SEL = 3;

    // uio_out status bits
    localparam int ST_CARRY = 4;
    localparam int ST_ZERO  = 5;
    localparam int ST_OVF   = 6;
    localparam int ST_BUSY  = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

    typedef struct packed {
        op_e        op;
        logic [7:0] a;
    } cmd_t;

endpackage

// File: rtl/tt_acc_sync_edge.sv
// Strobe synchroniser (SYNC_STAGES flops) followed by a rising-edge detector.
// rise_o is combinational on the last sync flop and its one-cycle-delayed copy.
module tt_acc_sync_edge #(
    parameter int SYNC_STAGES = tt_acc_pkg::SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], strobe_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tt_um_accum_pipe.sv
// Two-stage strobed accumulator: synchronised strobe edge -> stage-1 capture -> acc update.
// Define TT_ACC_SAT_EN to clamp ADD/SUB on carry/borrow instead of wrapping.
module tt_um_accum_pipe
    import tt_acc_pkg::*;
#(
    parameter int ACC_W       = ACC_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

`ifdef TT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic stb_rise, accept;

    tt_acc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .strobe_i(uio_in[CTRL_STB]),
        .rise_o  (stb_rise)
    );

    // ena only gates acceptance; a captured command always completes.
    assign accept = stb_rise & ena;

    cmd_t s1_q, s1_d;
    logic s1_vld_q;

    assign s1_d = '{op: op_e'(uio_in[1:0]), a: ui_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) s1_q <= s1_d;
        end
    end

    logic [ACC_W-1:0] acc_q, acc_d, a_ext;
    logic             carry_q, carry_d, ovf_q, ovf_d;
    logic [ACC_W:0]   sum, diff;

    assign a_ext = ACC_W'(s1_q.a);
    assign sum   = {1'b0, acc_q} + {1'b0, a_ext};
    assign diff  = {1'b0, acc_q} - {1'b0, a_ext};

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (s1_vld_q) begin
            case (s1_q.op)
                OP_LOAD: begin
                    acc_d   = a_ext;
                    carry_d = 1'b0;
                end
                OP_ADD: begin
                    carry_d = sum[ACC_W];
                    acc_d   = (SAT && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
                    ovf_d   = ovf_q | sum[ACC_W];
                end
                OP_SUB: begin
                    carry_d = diff[ACC_W];
                    acc_d   = (SAT && diff[ACC_W]) ? '0 : diff[ACC_W-1:0];
                    ovf_d   = ovf_q | diff[ACC_W];
                end
                default: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Upper byte is zero-padded; for ACC_W = 8 the shift leaves nothing.
    logic [7:0] acc_hi;
    logic       zero;

    assign acc_hi  = 8'(acc_q >> 8);
    assign zero    = (acc_q == '0);
    assign uo_out  = uio_in[CTRL_SEL] ? acc_hi : acc_q[7:0];
    assign uio_out = {s1_vld_q, ovf_q, zero, carry_q, 4'b0000};
    assign uio_oe  = UIO_OE_VAL;

    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_accum_pipe.sv
// Randomised + directed bench: a 16-bit/2-stage and an 8-bit/3-stage instance share
// stimulus and are compared against a plain-arithmetic accumulator model.
module tb_tt_um_accum_pipe;

`ifdef TT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo16, uio16, oe16, uo8, uio8, oe8;

    int vec_cnt = 0;
    int err_cnt = 0;

    int macc [2];
    bit mc   [2];
    bit mo   [2];

    always #5 clk = ~clk;

    tt_um_accum_pipe dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo16), .uio_out(uio16), .uio_oe(oe16)
    );

    tt_um_accum_pipe #(.ACC_W(8), .SYNC_STAGES(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo8), .uio_out(uio8), .uio_oe(oe8)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            macc[i] = 0; mc[i] = 0; mo[i] = 0;
        end
    endtask

    task automatic model_apply(input int i, input logic [1:0] op, input logic [7:0] a);
        int lim, r;
        lim = (i == 0) ? 65536 : 256;
        case (op)
            2'd0: begin macc[i] = int'(a); mc[i] = 0; end
            2'd1: begin
                r = macc[i] + int'(a);
                mc[i] = (r >= lim);
                macc[i] = mc[i] ? (SAT ? lim - 1 : r - lim) : r;
                mo[i] = mo[i] | mc[i];
            end
            2'd2: begin
                r = macc[i] - int'(a);
                mc[i] = (r < 0);
                macc[i] = mc[i] ? (SAT ? 0 : r + lim) : r;
                mo[i] = mo[i] | mc[i];
            end
            default: begin macc[i] = 0; mc[i] = 0; mo[i] = 0; end
        endcase
    endtask

    function automatic logic [7:0] exp_uo(input int i, input bit sel);
        return sel ? 8'((macc[i] >> 8) & 255) : 8'(macc[i] & 255);
    endfunction

    function automatic logic [7:0] exp_st(input int i, input bit busy);
        return {busy, mo[i], (macc[i] == 0), mc[i], 4'b0000};
    endfunction

    // Idle-state check of both instances, for both byte selects.
    task automatic check_all(input string tag);
        for (int s = 0; s < 2; s++) begin
            uio_in[3] = s[0];
            #1;
            check({tag, "/uo16"}, uo16, exp_uo(0, s[0]));
            check({tag, "/uo8"},  uo8,  exp_uo(1, s[0]));
        end
        check({tag, "/st16"}, uio16, exp_st(0, 1'b0));
        check({tag, "/st8"},  uio8,  exp_st(1, 1'b0));
        check({tag, "/oe16"}, oe16, 8'hF0);
        check({tag, "/oe8"},  oe8,  8'hF0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input int hold, input bit en,
                          input string tag);
        @(negedge clk);
        ena    = en;
        ui_in  = a;
        uio_in = {4'($urandom), uio_in[3], 1'b1, op};
        repeat (hold) @(negedge clk);
        uio_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        ena = 1'b1;
        if (en) begin
            model_apply(0, op, a);
            model_apply(1, op, a);
        end
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all("rst_rel");

        // LOAD F0 latency and busy width
        @(negedge clk);
        ui_in = 8'hF0; uio_in = 8'h04;
        @(posedge clk);
        @(negedge clk); uio_in[2] = 1'b0;
        check("busy16_k",  uio16[7], 1'b0);
        @(negedge clk);
        check("busy16_k1", uio16[7], 1'b0);
        check("busy8_k1",  uio8[7],  1'b0);
        @(negedge clk);
        check("busy16_k2", uio16[7], 1'b1);
        check("uo16_k2",   uo16,     8'h00);
        check("busy8_k2",  uio8[7],  1'b0);
        @(negedge clk);
        check("busy16_k3", uio16[7], 1'b0);
        check("uo16_k3",   uo16,     8'hF0);
        check("busy8_k3",  uio8[7],  1'b1);
        @(negedge clk);
        check("busy8_k4",  uio8[7],  1'b0);
        check("uo8_k4",    uo8,      8'hF0);
        model_apply(0, 2'd0, 8'hF0);
        model_apply(1, 2'd0, 8'hF0);
        check_all("load_f0");

        // Overflow on the narrow instance
        do_cmd(2'd0, 8'hFF, 1, 1'b1, "load_ff");
        do_cmd(2'd1, 8'h01, 1, 1'b1, "add_01");
        check("ovf8_add", uio8[6], 1'b1);
        check("cy8_add",  uio8[4], 1'b1);
        uio_in[3] = 1'b0; #1;
        check("uo8_add",  uo8, SAT ? 8'hFF : 8'h00);

        // Borrow on the wide instance
        do_cmd(2'd0, 8'h00, 1, 1'b1, "load_00");
        do_cmd(2'd2, 8'h01, 2, 1'b1, "sub_01");
        for (int s = 0; s < 2; s++) begin
            uio_in[3] = s[0]; #1;
            check("uo16_sub", uo16, SAT ? 8'h00 : 8'hFF);
        end

        // Long strobe issues one command
        do_cmd(2'd0, 8'h10, 1, 1'b1, "load_10");
        do_cmd(2'd1, 8'h05, 20, 1'b1, "add_hold");
        uio_in[3] = 1'b0; #1;
        check("uo16_hold", uo16, 8'h15);

        // ena low: no effect; then CLEAR after overflow
        do_cmd(2'd1, 8'h40, 2, 1'b0, "ena_off");
        do_cmd(2'd0, 8'hFF, 1, 1'b1, "load_ff2");
        do_cmd(2'd1, 8'hFF, 1, 1'b1, "add_ff");
        do_cmd(2'd3, 8'h00, 1, 1'b1, "clear");
        check("st16_clr", uio16, 8'h20);
        check("st8_clr",  uio8,  8'h20);

        // ena drop after wide capture: wide completes, narrow never accepts
        do_cmd(2'd0, 8'h30, 1, 1'b1, "load_30");
        @(negedge clk);
        ui_in = 8'h22; uio_in = 8'h05;
        @(posedge clk);
        @(negedge clk); uio_in[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy16_ena", uio16[7], 1'b1);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        model_apply(0, 2'd1, 8'h22);
        check_all("ena_drop");

        // Reset while a command sits in stage 1
        @(negedge clk);
        ui_in = 8'h10; uio_in = 8'h05;
        @(posedge clk);
        @(negedge clk); uio_in[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy16_fl", uio16[7], 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("uo16_fl", uo16, 8'h00);
        check("st16_fl", uio16, 8'h20);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_all("inflight");

        // Strobe already high at reset release
        rst_n = 1'b0;
        ui_in = 8'h33; uio_in = 8'h04;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        uio_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        model_apply(0, 2'd0, 8'h33);
        model_apply(1, 2'd0, 8'h33);
        check_all("stb_at_rel");

        for (int n = 0; n < 80; n++) begin
            logic [1:0] op;
            logic [7:0] a;
            int         r;
            op = 2'($urandom_range(0, 3));
            if (op == 2'd3 && $urandom_range(0, 1) == 0) op = 2'd1;
            r = $urandom_range(0, 7);
            a = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            do_cmd(op, a, $urandom_range(1, 4), ($urandom_range(0, 7) != 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
